// File: rtl/ddr3_app_resp.sv
// ddr3_app_resp
// Responder side of the MIG 7-series app interface. It stands in for the DDR3
// controller and DRAM so app-side initiators can be verified without the
// MIG/PHY. Commands and write data are queued in small FIFOs and executed in
// order against an internal word array. Reads return after a fixed latency.
// Calibration delay is emulated, and optional pseudo-random app_rdy
// backpressure is available.
//
// Ports
//   ui_clk               in   sole clock
//   ui_rst_n             in   synchronous reset, active low
//   app_addr             in   command address; index = app_addr[ADDR_SHIFT +: DEPTH_LOG2]
//   app_cmd              in   3'b000 write, 3'b001 read, anything else is illegal
//   app_en               in   command valid
//   app_rdy              out  command accept
//   app_wdf_data         in   write data
//   app_wdf_mask         in   byte mask, 1 = byte not written
//   app_wdf_wren         in   write data valid
//   app_wdf_end          in   last beat (single-beat only, ignored)
//   app_wdf_rdy          out  write data accept
//   app_rd_data          out  read data, holds its last value while not valid
//   app_rd_data_valid    out  read data valid
//   app_rd_data_end      out  same as app_rd_data_valid
//   init_calib_complete  out  emulated calibration done
//   cmd_err              out  one-cycle pulse after an illegal command executes

module ddr3_app_resp #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 256,
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_SHIFT = 3,
    parameter int CMD_DEPTH  = 4,
    parameter int WDF_DEPTH  = 4,
    parameter int RD_LAT     = 4,
    parameter int CALIB_CYC  = 64,
    parameter int STALL_EN   = 0
) (
    input  logic                ui_clk,
    input  logic                ui_rst_n,
    input  logic [ADDR_W-1:0]   app_addr,
    input  logic [2:0]          app_cmd,
    input  logic                app_en,
    output logic                app_rdy,
    input  logic [DATA_W-1:0]   app_wdf_data,
    input  logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_wren,
    input  logic                app_wdf_end,
    output logic                app_wdf_rdy,
    output logic [DATA_W-1:0]   app_rd_data,
    output logic                app_rd_data_valid,
    output logic                app_rd_data_end,
    output logic                init_calib_complete,
    output logic                cmd_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CPTR_W = $clog2(CMD_DEPTH);
    localparam int WPTR_W = $clog2(WDF_DEPTH);
    localparam int CAL_W  = $clog2(CALIB_CYC + 1);
    localparam int WORDS  = 2 ** DEPTH_LOG2;

    // command FIFO
    logic [2:0]            cmd_op  [CMD_DEPTH];
    logic [DEPTH_LOG2-1:0] cmd_idx [CMD_DEPTH];
    logic [CPTR_W-1:0]     cmd_wp, cmd_rp;
    logic [CPTR_W:0]       cmd_cnt;

    // write-data FIFO
    logic [DATA_W-1:0]     wdf_data [WDF_DEPTH];
    logic [MASK_W-1:0]     wdf_mask [WDF_DEPTH];
    logic [WPTR_W-1:0]     wdf_wp, wdf_rp;
    logic [WPTR_W:0]       wdf_cnt;

    logic [DATA_W-1:0]     mem [WORDS];

    logic [CAL_W-1:0]      calib_cnt;
    logic [15:0]           lfsr;
    logic                  stall;

    logic [RD_LAT-1:0]     rd_vld_pipe;
    logic [DATA_W-1:0]     rd_dat_pipe [RD_LAT];

    logic                  cmd_push, cmd_pop, wdf_push, wdf_pop;
    logic                  exec_wr, exec_rd, exec_ill;
    logic [2:0]            head_op;
    logic [DEPTH_LOG2-1:0] head_idx;

    logic                  unused_in;
    assign unused_in = ^{app_wdf_end,
                         app_addr[ADDR_W-1:ADDR_SHIFT+DEPTH_LOG2],
                         app_addr[ADDR_SHIFT-1:0]};

    // Depths are powers of two, so the count MSB alone means "full".
    assign stall       = (STALL_EN != 0) && (lfsr[2:0] == 3'b000);
    assign app_rdy     = init_calib_complete & ~cmd_cnt[CPTR_W] & ~stall;
    assign app_wdf_rdy = init_calib_complete & ~wdf_cnt[WPTR_W];

    assign cmd_push = app_en & app_rdy;
    assign wdf_push = app_wdf_wren & app_wdf_rdy;

    assign head_op  = cmd_op[cmd_rp];
    assign head_idx = cmd_idx[cmd_rp];

    // Executor: at most one command per cycle from the FIFO head. A write with
    // no data yet blocks the head, and everything behind it waits as well.
    always_comb begin
        exec_wr  = 1'b0;
        exec_rd  = 1'b0;
        exec_ill = 1'b0;
        if (ui_rst_n && (cmd_cnt != '0)) begin
            case (head_op)
                3'b000:  exec_wr  = (wdf_cnt != '0);
                3'b001:  exec_rd  = 1'b1;
                default: exec_ill = 1'b1;
            endcase
        end
    end

    assign cmd_pop = exec_wr | exec_rd | exec_ill;
    assign wdf_pop = exec_wr;

    // FIFO storage (not reset; pointers define validity)
    always_ff @(posedge ui_clk) begin
        if (cmd_push) begin
            cmd_op[cmd_wp]  <= app_cmd;
            cmd_idx[cmd_wp] <= app_addr[ADDR_SHIFT +: DEPTH_LOG2];
        end
        if (wdf_push) begin
            wdf_data[wdf_wp] <= app_wdf_data;
            wdf_mask[wdf_wp] <= app_wdf_mask;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
            wdf_wp  <= '0;
            wdf_rp  <= '0;
            wdf_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + CPTR_W'(1);
            if (cmd_pop)  cmd_rp <= cmd_rp + CPTR_W'(1);
            cmd_cnt <= cmd_cnt + {{CPTR_W{1'b0}}, cmd_push} - {{CPTR_W{1'b0}}, cmd_pop};
            if (wdf_push) wdf_wp <= wdf_wp + WPTR_W'(1);
            if (wdf_pop)  wdf_rp <= wdf_rp + WPTR_W'(1);
            wdf_cnt <= wdf_cnt + {{WPTR_W{1'b0}}, wdf_push} - {{WPTR_W{1'b0}}, wdf_pop};
        end
    end

    // Word array: contents survive reset. The write lands at this edge, so a
    // read one slot behind it in queue order sees the new data.
    always_ff @(posedge ui_clk) begin
        if (exec_wr) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wdf_mask[wdf_rp][b])
                    mem[head_idx][b*8 +: 8] <= wdf_data[wdf_rp][b*8 +: 8];
            end
        end
    end

    // Calibration: down-counter; done flag set on the CALIB_CYC-th edge after release.
    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n) begin
            calib_cnt           <= CAL_W'(CALIB_CYC);
            init_calib_complete <= 1'b0;
        end else if (!init_calib_complete) begin
            calib_cnt <= calib_cnt - CAL_W'(1);
            if (calib_cnt == CAL_W'(1))
                init_calib_complete <= 1'b1;
        end
    end

    // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting right.
    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Read pipeline: data captured at issue. The output register adds the final
    // stage, so valid rises RD_LAT edges after the issue edge.
    always_ff @(posedge ui_clk) begin
        rd_dat_pipe[0] <= mem[head_idx];
        for (int i = 1; i < RD_LAT; i++)
            rd_dat_pipe[i] <= rd_dat_pipe[i-1];
    end

    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n) begin
            rd_vld_pipe       <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
            cmd_err           <= 1'b0;
        end else begin
            rd_vld_pipe[0] <= exec_rd;
            for (int i = 1; i < RD_LAT; i++)
                rd_vld_pipe[i] <= rd_vld_pipe[i-1];
            app_rd_data_valid <= rd_vld_pipe[RD_LAT-1];
            if (rd_vld_pipe[RD_LAT-1])
                app_rd_data <= rd_dat_pipe[RD_LAT-1];
            cmd_err <= exec_ill;
        end
    end

    assign app_rd_data_end = app_rd_data_valid;

endmodule
